// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// field positions and the default halt opcode.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Instruction word layout: {opcode[15:9], dr[8:6], sa[5:3], sb[2:0]}
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 9;
  localparam int DR_MSB     = 8;
  localparam int DR_LSB     = 6;
  localparam int SA_MSB     = 5;
  localparam int SA_LSB     = 3;
  localparam int SB_MSB     = 2;
  localparam int SB_LSB     = 0;

  localparam logic [6:0] HALT_OP_DEFAULT = 7'h7F;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read bus between the sequencer (master) and the memory
// (slave): request/address out, acknowledge/data back.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);

  logic            im_req;
  logic [PC_W-1:0] im_addr;
  logic            im_ack;
  logic [15:0]     im_data;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_data
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_data
  );

endinterface

// File: rtl/instr_sequencer_pc_next.sv
// Combinational next-PC selection: sequential step, absolute jump through the
// A-bus, or a relative branch on the zero/negative status.
module pc_next #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            PL,
  input  logic            JB,
  input  logic            BC,
  input  logic            z,
  input  logic            n,
  input  logic [7:0]      ad_in,
  input  logic [5:0]      offset,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] branch_pc;
  logic [PC_W-1:0] jump_pc;
  logic            taken;

  // The signed cast sign-extends the 6-bit offset; the sum wraps at 2^PC_W.
  assign seq_pc    = pc + PC_W'(1);
  assign branch_pc = pc + PC_W'($signed(offset));
  assign jump_pc   = PC_W'(ad_in);
  assign taken     = BC ? n : z;

  always_comb begin
    next_pc = seq_pc;
    if (PL) begin
      if (JB) begin
        next_pc = jump_pc;
      end else if (taken) begin
        next_pc = branch_pc;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a word over the memory bus, presents its
// fields to the decoder, waits out datapath stalls, then updates the PC.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [6:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.master   im,
  output logic [6:0]          opcode,
  output logic [2:0]          dr,
  output logic [2:0]          sa,
  output logic [2:0]          sb,
  output logic [7:0]          constant_out,
  output logic                issue_valid,
  input  logic                stall,
  input  logic                PL,
  input  logic                JB,
  input  logic                BC,
  input  logic                z,
  input  logic                n,
  input  logic [7:0]          ad_in,
  output logic                halted,
  output logic [PC_W-1:0]     pc
);

  seq_state_t      state;
  seq_state_t      state_next;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_upd;
  logic            is_halt_op;

  assign opcode       = ir[OPCODE_MSB:OPCODE_LSB];
  assign dr           = ir[DR_MSB:DR_LSB];
  assign sa           = ir[SA_MSB:SA_LSB];
  assign sb           = ir[SB_MSB:SB_LSB];
  assign constant_out = {5'b0, sb};
  assign is_halt_op   = (opcode == HALT_OP);
  assign pc           = pc_q;
  assign im.im_addr   = pc_q;

  pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc      (pc_q),
    .PL      (PL),
    .JB      (JB),
    .BC      (BC),
    .z       (z),
    .n       (n),
    .ad_in   (ad_in),
    .offset  ({dr, sb}),
    .next_pc (pc_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH: if (im.im_ack) state_next = ISSUE;
      ISSUE: begin
        if (is_halt_op) begin
          state_next = HALT;
        end else if (!stall) begin
          state_next = EXEC;
        end
      end
      EXEC:  state_next = FETCH;
      HALT:  state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Strobes are masked by rst so a reset cycle never requests or issues.
  always_comb begin
    im.im_req   = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      im.im_req   = (state == FETCH);
      issue_valid = (state == ISSUE) && !is_halt_op && !stall;
      halted      = (state == HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= 16'h0000;
    end else if (state == FETCH && im.im_ack) begin
      ir <= im.im_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (state == EXEC) begin
      pc_q <= pc_upd;
    end
  end

endmodule
